frame_burst_writer: RTL and testbench
=====================================

FRAME_BURST_WRITER -- requirements
Module: frame_burst_writer

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, meaning words per full DDR write burst (1..64).
REQ-002 SHALL have parameter FRAME_WORDS, default 307200, meaning 32-bit point words per frame (640x480).
REQ-003 SHALL have parameter BASE_ADDR, default 30'h0, meaning frame-buffer byte address in DDR, 4-byte aligned.
REQ-004 SHALL have port clk  input  1  single clock for all logic (MCB port-0 user clock).
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port data  input  32  point word from the Mandelbrot rendering engine.
REQ-007 SHALL have port ready  input  1  engine holds a valid word on data.
REQ-008 SHALL have port frame_ready  input  1  one-cycle pulse: engine has delivered the frame's last word.
REQ-009 SHALL have port send_data  output  1  writer accepts data this cycle.
REQ-010 SHALL have port mem_calib_done  input  1  DDR calibration complete.
REQ-011 SHALL have ports p0_wr_full, p0_cmd_full  input  1 each  MCB write-data / command FIFO full.
REQ-012 SHALL have ports p0_wr_en (output 1), p0_wr_data (output 32)  MCB write-data FIFO push.
REQ-013 SHALL have ports p0_cmd_en (output 1), p0_cmd_instr (output 3), p0_cmd_bl (output 6), p0_cmd_byte_addr (output 30)  MCB command push.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse after frame's last command issued.

Function
REQ-015 SHALL implement states INIT, FILL, CMD; INIT->FILL on the first clk with mem_calib_done=1.
REQ-016 SHALL drive send_data=1 only in FILL when word_cnt<BURST_LEN and p0_wr_full=0.
REQ-017 SHALL accept a word on every clk where send_data=1 and ready=1; data ignored otherwise.
REQ-018 SHALL register each accepted word: p0_wr_en=1 and p0_wr_data=data exactly one clk after acceptance (latency 1), p0_wr_en=0 otherwise.
REQ-019 SHALL increment word_cnt (7 bits) and frame_idx (19 bits) per accepted word.
REQ-020 SHALL go FILL->CMD on the clk after word_cnt reaches BURST_LEN, or after frame_ready when word_cnt>0, so the command always follows its last p0_wr_en.
REQ-021 SHALL in CMD pulse p0_cmd_en for exactly one clk on the first clk with p0_cmd_full=0, with p0_cmd_instr=3'b000, p0_cmd_bl=word_cnt-1, p0_cmd_byte_addr=current address.
REQ-022 SHALL after the command advance address by word_cnt*4, clear word_cnt, return to FILL.
REQ-023 SHALL treat frame end as frame_ready=1 or frame_idx reaching FRAME_WORDS, whichever first.
REQ-024 SHALL at frame end reset address to BASE_ADDR and frame_idx to 0 after the final command, and pulse frame_done in the same clk as that command's p0_cmd_en.
REQ-025 SHALL on frame end with word_cnt=0 issue no command and pulse frame_done on the following clk.
REQ-026 SHALL on frame_ready coinciding with the acceptance completing a full burst issue one full burst (bl=BURST_LEN-1) and then wrap.
REQ-027 SHALL hold send_data=0 during CMD and INIT; p0_wr_full rising mid-FILL stalls acceptance without loss.
REQ-028 SHALL ignore mem_calib_done once out of INIT.

Reset
REQ-029 SHALL on reset_n=0 immediately force state INIT, send_data=0, p0_wr_en=0, p0_wr_data=0, p0_cmd_en=0, p0_cmd_instr=0, p0_cmd_bl=0, p0_cmd_byte_addr=BASE_ADDR, frame_done=0, counters 0.
REQ-030 SHALL discard any partially collected burst when reset asserts mid-operation; no command issued for it.
REQ-031 SHALL resume only through INIT after reset_n deasserts.

Verification
REQ-032 Bench: calib=0, ready=1 for 10 clks -> send_data=0, no p0_wr_en; calib=1 -> send_data=1 next clk.
REQ-033 Bench: BURST_LEN=32, 32 words 0..31 streamed -> 32 p0_wr_en pulses in order, one p0_cmd_en with bl=31, addr=0; next burst addr=128.
REQ-034 Bench: frame_ready after 5 words of a burst -> p0_cmd_en with bl=4, frame_done same clk, next command addr=BASE_ADDR.
REQ-035 Bench: p0_cmd_full=1 for 20 clks in CMD -> p0_cmd_en held 0, send_data=0; p0_cmd_full=0 -> single p0_cmd_en pulse.
REQ-036 Bench: p0_wr_full=1 after word 10 -> send_data=0, no words lost, 32nd word still written before command.
REQ-037 Bench: reset_n=0 after 7 words -> all outputs reset values asynchronously; after release, first command addr=BASE_ADDR, bl=31.

Source files
------------

// File: rtl/frame_burst_writer.sv
// Collects point words from the rendering engine into DDR write bursts and
// issues one MCB port-0 write command per burst, wrapping the address at frame end.
module frame_burst_writer #(
  parameter int          BURST_LEN   = 32,
  parameter int          FRAME_WORDS = 307200,
  parameter logic [29:0] BASE_ADDR   = 30'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] data,
  input  logic        ready,
  input  logic        frame_ready,
  output logic        send_data,
  input  logic        mem_calib_done,
  input  logic        p0_wr_full,
  input  logic        p0_cmd_full,
  output logic        p0_wr_en,
  output logic [31:0] p0_wr_data,
  output logic        p0_cmd_en,
  output logic [2:0]  p0_cmd_instr,
  output logic [5:0]  p0_cmd_bl,
  output logic [29:0] p0_cmd_byte_addr,
  output logic        frame_done
);

  localparam logic [6:0]  BURST_CNT  = 7'(BURST_LEN);
  localparam logic [18:0] FRAME_LAST = 19'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {INIT, FILL, CMD} state_t;

  state_t      state_reg, state_next;
  logic [6:0]  word_cnt_reg;
  logic [18:0] frame_idx_reg;
  logic [29:0] addr_reg;
  logic        frame_end_reg;
  logic        empty_done_reg;
  logic        wr_en_reg;
  logic [31:0] wr_data_reg;

  logic accept;
  logic frame_end_in;
  logic empty_end;
  logic cmd_issue;
  logic final_cmd;

  // Once the frame has ended, stop accepting until its last burst is commanded.
  always_comb begin
    state_next = state_reg;
    send_data  = 1'b0;
    case (state_reg)
      INIT: begin
        if (mem_calib_done) state_next = FILL;
      end
      FILL: begin
        send_data = (word_cnt_reg < BURST_CNT) && !p0_wr_full && !frame_end_reg;
        if ((word_cnt_reg == BURST_CNT) || (frame_end_reg && (word_cnt_reg != 7'd0)))
          state_next = CMD;
      end
      CMD: begin
        if (!p0_cmd_full) state_next = FILL;
      end
      default: state_next = INIT;
    endcase
  end

  assign accept       = send_data & ready;
  assign frame_end_in = (state_reg == FILL) &&
                        (frame_ready || (accept && (frame_idx_reg == FRAME_LAST)));
  // Frame ended with nothing buffered: no command, just the done pulse next cycle.
  assign empty_end    = frame_end_in && !accept && (word_cnt_reg == 7'd0) && !frame_end_reg;
  assign cmd_issue    = (state_reg == CMD) && !p0_cmd_full;
  assign final_cmd    = frame_end_reg || frame_ready;

  assign p0_wr_en         = wr_en_reg;
  assign p0_wr_data       = wr_data_reg;
  assign p0_cmd_en        = cmd_issue;
  assign p0_cmd_instr     = 3'b000;
  assign p0_cmd_bl        = (state_reg == CMD) ? 6'(word_cnt_reg - 7'd1) : 6'd0;
  assign p0_cmd_byte_addr = addr_reg;
  assign frame_done       = (cmd_issue && final_cmd) || empty_done_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= INIT;
      word_cnt_reg   <= 7'd0;
      frame_idx_reg  <= 19'd0;
      addr_reg       <= BASE_ADDR;
      frame_end_reg  <= 1'b0;
      empty_done_reg <= 1'b0;
      wr_en_reg      <= 1'b0;
      wr_data_reg    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      wr_en_reg      <= accept;
      empty_done_reg <= empty_end;
      if (accept) begin
        wr_data_reg   <= data;
        word_cnt_reg  <= word_cnt_reg + 7'd1;
        frame_idx_reg <= frame_idx_reg + 19'd1;
      end
      if (frame_end_in && !empty_end) frame_end_reg <= 1'b1;
      // A frame_ready arriving while the command is stalled must not be lost.
      if ((state_reg == CMD) && frame_ready) frame_end_reg <= 1'b1;
      if (empty_end) begin
        addr_reg      <= BASE_ADDR;
        frame_idx_reg <= 19'd0;
      end
      if (cmd_issue) begin
        word_cnt_reg <= 7'd0;
        if (final_cmd) begin
          addr_reg      <= BASE_ADDR;
          frame_idx_reg <= 19'd0;
          frame_end_reg <= 1'b0;
        end else begin
          addr_reg <= addr_reg + {21'd0, word_cnt_reg, 2'b00};
        end
      end
    end
  end

endmodule

// File: tb/tb_frame_burst_writer.sv
// Self-checking bench for frame_burst_writer: directed scenarios plus a randomized
// multi-frame run compared against a burst/frame model built from plain arithmetic.
module tb_frame_burst_writer;

  localparam int          BL   = 32;
  localparam int          FW   = 100;
  localparam logic [29:0] BASE = 30'h400;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data = 32'd0;
  logic        ready = 1'b0;
  logic        frame_ready = 1'b0;
  logic        mem_calib_done = 1'b0;
  logic        p0_wr_full = 1'b0;
  logic        p0_cmd_full = 1'b0;
  logic        send_data;
  logic        p0_wr_en;
  logic [31:0] p0_wr_data;
  logic        p0_cmd_en;
  logic [2:0]  p0_cmd_instr;
  logic [5:0]  p0_cmd_bl;
  logic [29:0] p0_cmd_byte_addr;
  logic        frame_done;

  always #5 clk = ~clk;

  frame_burst_writer #(.BURST_LEN(BL), .FRAME_WORDS(FW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset_n(reset_n), .data(data), .ready(ready), .frame_ready(frame_ready),
    .send_data(send_data), .mem_calib_done(mem_calib_done), .p0_wr_full(p0_wr_full),
    .p0_cmd_full(p0_cmd_full), .p0_wr_en(p0_wr_en), .p0_wr_data(p0_wr_data),
    .p0_cmd_en(p0_cmd_en), .p0_cmd_instr(p0_cmd_instr), .p0_cmd_bl(p0_cmd_bl),
    .p0_cmd_byte_addr(p0_cmd_byte_addr), .frame_done(frame_done)
  );

  typedef struct {
    logic [5:0]  bl;
    logic [29:0] addr;
    logic        done;
    int          nwr;
  } cmd_t;

  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          wr_since = 0;
  bit          rnd_wr_full = 1'b0;
  logic [31:0] wr_log[$];
  logic [31:0] sent_q[$];
  cmd_t        cmd_log[$];
  cmd_t        exp_q[$];
  int          done_cyc[$];
  cmd_t        mon_c;
  int          seg_n[4];
  int          seg_mode[4];

  always @(posedge clk) cyc++;

  // Observer: records every write push and command (with writes seen since the previous one).
  always @(negedge clk) begin
    if (p0_cmd_en) begin
      mon_c.bl   = p0_cmd_bl;
      mon_c.addr = p0_cmd_byte_addr;
      mon_c.done = frame_done;
      mon_c.nwr  = wr_since;
      cmd_log.push_back(mon_c);
      wr_since = 0;
      $display("cmd  bl=%0d addr=0x%08h frame_done=%0b writes=%0d", p0_cmd_bl, p0_cmd_byte_addr, frame_done, mon_c.nwr);
    end else if (frame_done) begin
      done_cyc.push_back(cyc);
      $display("done (no command) cycle=%0d", cyc);
    end
    if (p0_wr_en) begin
      wr_log.push_back(p0_wr_data);
      wr_since++;
    end
  end

  task automatic do_reset();
    reset_n = 1'b0;
    ready = 1'b0;
    frame_ready = 1'b0;
    mem_calib_done = 1'b0;
    p0_wr_full = 1'b0;
    p0_cmd_full = 1'b0;
    rnd_wr_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    wr_log.delete();
    sent_q.delete();
    cmd_log.delete();
    done_cyc.delete();
    wr_since = 0;
    reset_n = 1'b1;
  endtask

  task automatic start();
    mem_calib_done = 1'b1;
    @(posedge clk);
    #1;
    mem_calib_done = 1'($urandom_range(0, 1));
  endtask

  // mode: 0 no frame_ready, 1 frame_ready with last acceptance, 2 frame_ready the cycle after.
  task automatic stream(input int n, input logic [31:0] base, input bit rnd_data, input int mode,
                        input int stall_at, input int stall_len, output int stall_bad);
    logic [31:0] w;
    int i = 0;
    int budget = 0;
    int stall_left = stall_len;
    bit stalled;
    stall_bad = 0;
    w = rnd_data ? $urandom : base;
    while (i < n) begin
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
      stalled = (i == stall_at) && (stall_left > 0);
      if (stalled) begin
        p0_wr_full = 1'b1;
        stall_left--;
      end else begin
        p0_wr_full = rnd_wr_full ? ($urandom_range(0, 7) == 0) : 1'b0;
      end
      ready = stalled || ($urandom_range(0, 3) != 0);
      data = w;
      #1;
      if (p0_wr_full && send_data) stall_bad++;
      if (ready && send_data) begin
        sent_q.push_back(w);
        if ((i == n - 1) && (mode == 1)) frame_ready = 1'b1;
        i++;
        w = rnd_data ? $urandom : base + 32'(i);
      end
      budget++;
      if (budget > 3000) begin
        total++;
        $display("FAIL stream_timeout: accepted %0d words, required %0d", i, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    ready = 1'b0;
    p0_wr_full = 1'b0;
    frame_ready = (mode == 2);
    if (mode == 2) begin
      @(posedge clk);
      #1;
      frame_ready = 1'b0;
    end
  endtask

  task automatic wait_cmds(input int k, input string tag);
    int b = 0;
    while ((cmd_log.size() < k) && (b < 400)) begin
      @(posedge clk);
      b++;
    end
    #1;
    if (cmd_log.size() < k) begin
      total++;
      $display("FAIL %s_cmd_timeout: saw %0d commands, required %0d", tag, cmd_log.size(), k);
    end
  endtask

  // Reference: split the accepted word stream into bursts at BL words and at every frame end.
  function automatic void build_model();
    logic [29:0] a = BASE;
    int cnt = 0;
    int pos = 0;
    bit end_here;
    cmd_t e;
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < seg_n[s]; k++) begin
        cnt++;
        pos++;
        end_here = ((k == seg_n[s] - 1) && (seg_mode[s] != 0)) || (pos == FW);
        if ((cnt == BL) || end_here) begin
          e.bl = 6'(cnt - 1);
          e.addr = a;
          e.done = end_here;
          e.nwr = cnt;
          exp_q.push_back(e);
          if (end_here) begin
            a = BASE;
            pos = 0;
          end else begin
            a = a + 30'(cnt * 4);
          end
          cnt = 0;
        end
      end
    end
  endfunction

  task automatic test_reset();
    @(posedge clk);
    #2;
    total++;
    if ({send_data, p0_wr_en, p0_cmd_en, frame_done} !== 4'b0000)
      $display("FAIL reset_ctrl: got %b required 0000", {send_data, p0_wr_en, p0_cmd_en, frame_done});
    else passed++;
    total++;
    if (p0_wr_data !== 32'h0) $display("FAIL reset_wr_data: got %h required 0", p0_wr_data);
    else passed++;
    total++;
    if ({p0_cmd_instr, p0_cmd_bl} !== 9'h0) $display("FAIL reset_instr_bl: got %h required 0", {p0_cmd_instr, p0_cmd_bl});
    else passed++;
    total++;
    if (p0_cmd_byte_addr !== BASE) $display("FAIL reset_addr: got %h required %h", p0_cmd_byte_addr, BASE);
    else passed++;
  endtask

  task automatic test_calib();
    int sd = 0;
    do_reset();
    ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (send_data) sd++;
    end
    total++;
    if (sd !== 0) $display("FAIL calib_send_data: high %0d cycles, required 0", sd);
    else passed++;
    total++;
    if (wr_log.size() !== 0) $display("FAIL calib_wr_en: got %0d pushes, required 0", wr_log.size());
    else passed++;
    mem_calib_done = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (send_data !== 1'b1) $display("FAIL calib_release: send_data %b required 1", send_data);
    else passed++;
    ready = 1'b0;
  endtask

  task automatic test_full_burst();
    int bad = 0;
    int sb;
    do_reset();
    start();
    stream(64, 32'd0, 1'b0, 0, -1, 0, sb);
    wait_cmds(2, "full_burst");
    total++;
    if (wr_log.size() !== 64) $display("FAIL burst_wr_count: got %0d required 64", wr_log.size());
    else passed++;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 32'(i)) bad++;
    total++;
    if (bad !== 0) $display("FAIL burst_wr_order: %0d words out of place, required 0", bad);
    else passed++;
    if (cmd_log.size() >= 2) begin
      total++;
      if ({cmd_log[0].bl, cmd_log[0].addr, cmd_log[0].done} !== {6'd31, BASE, 1'b0} || cmd_log[0].nwr != 32)
        $display("FAIL burst_cmd0: bl=%0d addr=%h done=%b writes=%0d required bl=31 addr=%h done=0 writes=32",
                 cmd_log[0].bl, cmd_log[0].addr, cmd_log[0].done, cmd_log[0].nwr, BASE);
      else passed++;
      total++;
      if ({cmd_log[1].bl, cmd_log[1].addr} !== {6'd31, BASE + 30'd128})
        $display("FAIL burst_cmd1: bl=%0d addr=%h required bl=31 addr=%h", cmd_log[1].bl, cmd_log[1].addr, BASE + 30'd128);
      else passed++;
    end
  endtask

  task automatic test_frame_ready();
    int sb;
    int mode = $urandom_range(1, 2);
    do_reset();
    start();
    stream(5, 32'hA000, 1'b0, mode, -1, 0, sb);
    wait_cmds(1, "frame_ready");
    stream(32, 32'hB000, 1'b0, 0, -1, 0, sb);
    wait_cmds(2, "frame_ready_next");
    if (cmd_log.size() >= 2) begin
      total++;
      if ({cmd_log[0].bl, cmd_log[0].addr, cmd_log[0].done} !== {6'd4, BASE, 1'b1} || cmd_log[0].nwr != 5)
        $display("FAIL partial_cmd (mode %0d): bl=%0d addr=%h done=%b writes=%0d required bl=4 addr=%h done=1 writes=5",
                 mode, cmd_log[0].bl, cmd_log[0].addr, cmd_log[0].done, cmd_log[0].nwr, BASE);
      else passed++;
      total++;
      if ({cmd_log[1].bl, cmd_log[1].addr, cmd_log[1].done} !== {6'd31, BASE, 1'b0})
        $display("FAIL wrap_cmd: bl=%0d addr=%h done=%b required bl=31 addr=%h done=0",
                 cmd_log[1].bl, cmd_log[1].addr, cmd_log[1].done, BASE);
      else passed++;
    end
  endtask

  task automatic test_empty_end();
    int sb;
    int c;
    do_reset();
    start();
    stream(32, 32'hC000, 1'b0, 0, -1, 0, sb);
    wait_cmds(1, "empty_pre");
    repeat (2) @(posedge clk);
    #1;
    frame_ready = 1'b1;
    c = cyc;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_log.size() !== 1) $display("FAIL empty_no_cmd: got %0d commands required 1", cmd_log.size());
    else passed++;
    total++;
    if (done_cyc.size() !== 1) $display("FAIL empty_done_count: got %0d pulses required 1", done_cyc.size());
    else if (done_cyc[0] !== c + 1) $display("FAIL empty_done_cycle: got %0d required %0d", done_cyc[0], c + 1);
    else passed++;
    stream(32, 32'hD000, 1'b0, 0, -1, 0, sb);
    wait_cmds(2, "empty_post");
    if (cmd_log.size() >= 2) begin
      total++;
      if (cmd_log[1].addr !== BASE) $display("FAIL empty_wrap_addr: got %h required %h", cmd_log[1].addr, BASE);
      else passed++;
    end
  endtask

  task automatic test_cmd_full();
    int sb;
    int bad = 0;
    do_reset();
    start();
    p0_cmd_full = 1'b1;
    stream(32, 32'hE000, 1'b0, 0, -1, 0, sb);
    repeat (20) begin
      @(posedge clk);
      #1;
      ready = 1'b1;
      #1;
      if (p0_cmd_en || send_data) bad++;
    end
    total++;
    if (bad !== 0) $display("FAIL cmd_full_hold: %0d cycles with cmd_en/send_data high, required 0", bad);
    else passed++;
    total++;
    if ((cmd_log.size() !== 0) || (wr_log.size() !== 32))
      $display("FAIL cmd_full_counts: cmds=%0d writes=%0d required cmds=0 writes=32", cmd_log.size(), wr_log.size());
    else passed++;
    p0_cmd_full = 1'b0;
    ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cmd_log.size() !== 1) $display("FAIL cmd_full_release: got %0d commands required 1", cmd_log.size());
    else if (cmd_log[0].bl !== 6'd31) $display("FAIL cmd_full_release: bl=%0d required 31", cmd_log[0].bl);
    else passed++;
  endtask

  task automatic test_wr_full();
    int sb;
    int bad = 0;
    do_reset();
    start();
    stream(32, 32'd0, 1'b0, 0, 10, $urandom_range(5, 15), sb);
    wait_cmds(1, "wr_full");
    total++;
    if (sb !== 0) $display("FAIL wr_full_stall: send_data high %0d cycles while full, required 0", sb);
    else passed++;
    for (int i = 0; i < wr_log.size(); i++) if (wr_log[i] !== 32'(i)) bad++;
    total++;
    if ((wr_log.size() !== 32) || (bad !== 0))
      $display("FAIL wr_full_words: writes=%0d misplaced=%0d required 32 and 0", wr_log.size(), bad);
    else passed++;
    if (cmd_log.size() >= 1) begin
      total++;
      if ((cmd_log[0].bl !== 6'd31) || (cmd_log[0].nwr != 32))
        $display("FAIL wr_full_cmd: bl=%0d writes=%0d required 31 and 32", cmd_log[0].bl, cmd_log[0].nwr);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    int sb;
    do_reset();
    start();
    stream(7, 32'h7000, 1'b0, 0, -1, 0, sb);
    total++;
    if (p0_wr_en !== 1'b1) $display("FAIL mid_pre_wr_en: got %b required 1", p0_wr_en);
    else passed++;
    #1;
    reset_n = 1'b0;
    #1;
    total++;
    if ({send_data, p0_wr_en, p0_cmd_en, frame_done} !== 4'b0000)
      $display("FAIL mid_reset_ctrl: got %b required 0000", {send_data, p0_wr_en, p0_cmd_en, frame_done});
    else passed++;
    total++;
    if ((p0_wr_data !== 32'h0) || (p0_cmd_bl !== 6'h0) || (p0_cmd_byte_addr !== BASE))
      $display("FAIL mid_reset_data: wr_data=%h bl=%0d addr=%h required 0, 0, %h", p0_wr_data, p0_cmd_bl, p0_cmd_byte_addr, BASE);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (cmd_log.size() !== 0) $display("FAIL mid_reset_discard: got %0d commands required 0", cmd_log.size());
    else passed++;
    do_reset();
    start();
    stream(32, 32'h8000, 1'b0, 0, -1, 0, sb);
    wait_cmds(1, "mid_reset");
    if (cmd_log.size() >= 1) begin
      total++;
      if ({cmd_log[0].bl, cmd_log[0].addr} !== {6'd31, BASE} || cmd_log[0].nwr != 32)
        $display("FAIL mid_reset_resume: bl=%0d addr=%h writes=%0d required bl=31 addr=%h writes=32",
                 cmd_log[0].bl, cmd_log[0].addr, cmd_log[0].nwr, BASE);
      else passed++;
    end
  endtask

  task automatic test_random();
    int sb;
    int bad = 0;
    bit rnd_stop = 1'b0;
    for (int s = 0; s < 4; s++) begin
      seg_mode[s] = (s == 2) ? 0 : $urandom_range(0, 2);
      seg_n[s] = (seg_mode[s] == 0) ? FW : $urandom_range(1, FW);
    end
    build_model();
    do_reset();
    start();
    rnd_wr_full = 1'b1;
    fork
      begin
        for (int s = 0; s < 4; s++) stream(seg_n[s], 32'd0, 1'b1, seg_mode[s], -1, 0, sb);
        wait_cmds(exp_q.size(), "random");
        rnd_stop = 1'b1;
      end
      begin
        while (!rnd_stop) begin
          @(posedge clk);
          #1;
          p0_cmd_full = ($urandom_range(0, 3) == 0);
        end
        p0_cmd_full = 1'b0;
      end
    join
    rnd_wr_full = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (cmd_log.size() !== exp_q.size()) $display("FAIL rand_cmd_count: got %0d required %0d", cmd_log.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < cmd_log.size() && i < exp_q.size(); i++) begin
      total++;
      if ({cmd_log[i].bl, cmd_log[i].addr, cmd_log[i].done} !== {exp_q[i].bl, exp_q[i].addr, exp_q[i].done} ||
          cmd_log[i].nwr != exp_q[i].nwr)
        $display("FAIL rand_cmd[%0d]: bl=%0d addr=%h done=%b writes=%0d required bl=%0d addr=%h done=%b writes=%0d",
                 i, cmd_log[i].bl, cmd_log[i].addr, cmd_log[i].done, cmd_log[i].nwr,
                 exp_q[i].bl, exp_q[i].addr, exp_q[i].done, exp_q[i].nwr);
      else passed++;
    end
    for (int i = 0; i < wr_log.size() && i < sent_q.size(); i++) if (wr_log[i] !== sent_q[i]) bad++;
    total++;
    if ((wr_log.size() !== sent_q.size()) || (bad !== 0))
      $display("FAIL rand_words: writes=%0d sent=%0d misplaced=%0d required equal counts and 0",
               wr_log.size(), sent_q.size(), bad);
    else passed++;
    total++;
    if (done_cyc.size() !== 0) $display("FAIL rand_stray_done: got %0d required 0", done_cyc.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_calib();
    test_full_burst();
    test_frame_ready();
    test_empty_end();
    test_cmd_full();
    test_wr_full();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
